// File: rtl/serial_adder_fa_if.sv
// serial_adder_fa_if
//   Request/response bundle for the bit-serial adder.
//   master : drives start/a/b/cin and observes the result (the requester).
//   slave  : the adder itself.
// Signals
//   start    request; only taken when the adder is not busy
//   a, b     WIDTH-bit operands, captured on an accepted start
//   cin      carry-in, captured on an accepted start
//   busy     high while bits are being added
//   done     one-cycle pulse, sum/cout/ovf valid
//   sum      WIDTH-bit result, held until the next completed add
//   cout     carry out of the MSB
//   ovf      signed overflow
//   sum_bit  serial sum bit of the current step (debug), 0 when idle
interface serial_adder_fa_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;
  logic             sum_bit;

  modport master (
    output start, a, b, cin,
    input  busy, done, sum, cout, ovf, sum_bit
  );

  modport slave (
    input  start, a, b, cin,
    output busy, done, sum, cout, ovf, sum_bit
  );
endinterface

// File: rtl/serial_adder_fa.sv
// serial_adder_fa
//   Bit-serial WIDTH-bit adder: one full-adder cell plus a carry flop.
//   Operands load in parallel on an accepted start, are added LSB-first one
//   bit per clock, and the result is returned in parallel with carry-out and
//   signed overflow. Legal WIDTH is 2..32.
// Ports
//   clk   single clock, all state on posedge
//   rst   synchronous active-high reset; aborts an add in flight (no done)
//   bus   serial_adder_fa_if.slave (start/a/b/cin in; busy/done/sum/cout/
//         ovf/sum_bit out)
// Timing
//   start accepted at edge k -> busy for the WIDTH cycles after edges
//   k..k+WIDTH-1 -> done in the cycle after edge k+WIDTH. A start seen while
//   in DONE is accepted directly, giving one add per WIDTH+1 cycles.

// Single full-adder cell; the whole datapath reuses this one instance.
module serial_adder_fa_cell (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x ^ y));
endmodule

module serial_adder_fa #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_adder_fa_if.slave  bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand shift registers drain LSB-first; the result register fills from
  // the MSB side so that after WIDTH steps bit 0 lands in position 0.
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             carry;
  logic [CW-1:0]    cnt;

  // Architectural outputs, touched only on the step that enters DONE.
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;

  logic fa_s;
  logic fa_co;
  logic in_add;
  logic last;
  logic accept;

  serial_adder_fa_cell u_fa (
    .x  (a_sh[0]),
    .y  (b_sh[0]),
    .ci (carry),
    .s  (fa_s),
    .co (fa_co)
  );

  assign in_add = (state == S_ADD);
  assign last   = in_add && (cnt == CW'(WIDTH - 1));
  // Start is only ignored while adding; in DONE it chains straight into ADD.
  assign accept = bus.start && !in_add;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_ADD;
      S_ADD:   if (last)      state_nxt = S_DONE;
      S_DONE:  state_nxt = bus.start ? S_ADD : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy    = in_add;
    bus.done    = (state == S_DONE);
    bus.sum_bit = in_add ? fa_s : 1'b0;
    bus.sum     = sum_q;
    bus.cout    = cout_q;
    bus.ovf     = ovf_q;
  end

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else if (accept) begin
      a_sh   <= bus.a;
      b_sh   <= bus.b;
      res_sh <= '0;
      carry  <= bus.cin;
      cnt    <= '0;
    end else if (in_add) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= {fa_s, res_sh[WIDTH-1:1]};
      carry  <= fa_co;
      cnt    <= cnt + CW'(1);
    end
  end

  // The final bit is folded in directly so the result is visible in the
  // same cycle as done. On the last step the carry flop holds the carry into
  // the MSB, so it XOR the cell's carry-out is the signed overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last) begin
      sum_q  <= {fa_s, res_sh[WIDTH-1:1]};
      cout_q <= fa_co;
      ovf_q  <= carry ^ fa_co;
    end
  end
endmodule

// File: tb/tb_serial_adder_fa.sv
module tb_serial_adder_fa;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_adder_fa_if #(.WIDTH(8)) bus8 ();
  serial_adder_fa_if #(.WIDTH(2)) bus2 ();

  serial_adder_fa #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  serial_adder_fa #(.WIDTH(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  typedef struct {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t q8[$];
  exp_t q2[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference: unsigned sum for {cout,sum}, signed range test for ovf.
  function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b, input logic cin);
    exp_t   e;
    longint ua, ub, full, sa, sb, s, lim;
    ua   = longint'(a);
    ub   = longint'(b);
    full = ua + ub + longint'(cin);
    e.sum  = 32'(full & ((longint'(1) << w) - 1));
    e.cout = full[w];
    sa  = a[w-1] ? ua - (longint'(1) << w) : ua;
    sb  = b[w-1] ? ub - (longint'(1) << w) : ub;
    s   = sa + sb + longint'(cin);
    lim = longint'(1) << (w - 1);
    e.ovf = (s > lim - 1) || (s < -lim);
    return e;
  endfunction

  // Scoreboards: every done pulse must match the oldest outstanding add.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && bus8.done) begin
      if (q8.size() == 0) chk("w8_spurious_done", 1, 0);
      else begin
        e = q8.pop_front();
        chk("w8_sum",  32'(bus8.sum),  e.sum);
        chk("w8_cout", 32'(bus8.cout), 32'(e.cout));
        chk("w8_ovf",  32'(bus8.ovf),  32'(e.ovf));
      end
    end
    if (!rst && bus2.done) begin
      if (q2.size() == 0) chk("w2_spurious_done", 1, 0);
      else begin
        e = q2.pop_front();
        chk("w2_sum",  32'(bus2.sum),  e.sum);
        chk("w2_cout", 32'(bus2.cout), 32'(e.cout));
        chk("w2_ovf",  32'(bus2.ovf),  32'(e.ovf));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full add on the WIDTH=8 unit with per-cycle busy/sum_bit checks.
  // Inputs are scrambled after capture; glitch>=0 fires an ignored start
  // in that step's cycle.
  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic cin, input int glitch);
    exp_t e;
    e = model(8, 32'(a), 32'(b), cin);
    bus8.a = a; bus8.b = b; bus8.cin = cin; bus8.start = 1'b1;
    tick();
    q8.push_back(e);
    bus8.start = 1'b0;
    bus8.a = 8'($urandom); bus8.b = 8'($urandom); bus8.cin = 1'($urandom);
    for (int i = 0; i < 8; i++) begin
      chk("busy",       32'(bus8.busy),    1);
      chk("sum_bit",    32'(bus8.sum_bit), 32'(e.sum[i]));
      chk("done_early", 32'(bus8.done),    0);
      if (i == glitch) begin
        bus8.start = 1'b1; bus8.a = ~a; bus8.b = ~b;
      end else bus8.start = 1'b0;
      tick();
    end
    chk("done_at_9",    32'(bus8.done),    1);
    chk("busy_in_done", 32'(bus8.busy),    0);
    chk("sum_bit_idle", 32'(bus8.sum_bit), 0);
    tick();
    chk("done_one_cycle", 32'(bus8.done), 0);
    chk("sum_hold",       32'(bus8.sum),  e.sum);
  endtask

  initial begin
    exp_t e;
    int   n;
    bit   seen;

    bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.cin = 1'b0;
    bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.cin = 1'b0;

    // Reset, with start held high to show it is overridden.
    rst = 1'b1;
    bus8.start = 1'b1;
    tick(); tick();
    chk("rst_busy",    32'(bus8.busy),    0);
    chk("rst_done",    32'(bus8.done),    0);
    chk("rst_sum",     32'(bus8.sum),     0);
    chk("rst_cout",    32'(bus8.cout),    0);
    chk("rst_ovf",     32'(bus8.ovf),     0);
    chk("rst_sum_bit", 32'(bus8.sum_bit), 0);
    bus8.start = 1'b0;
    rst = 1'b0;
    tick();

    run8(8'h35, 8'h4A, 1'b0, -1);
    run8(8'hFF, 8'h01, 1'b0, -1);
    run8(8'h80, 8'h80, 1'b0, -1);
    run8(8'hA5, 8'h3C, 1'b1, 3);    // ignored start in cycle 4
    run8(8'h7F, 8'h00, 1'b1, -1);   // leaves sum=80, ovf=1 for the abort test

    // Abort mid-add: reset in cycle 5, no done, outputs cleared.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b0; bus8.start = 1'b1;
    tick();
    bus8.start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    tick();
    chk("abort_busy", 32'(bus8.busy), 0);
    chk("abort_done", 32'(bus8.done), 0);
    chk("abort_sum",  32'(bus8.sum),  0);
    chk("abort_ovf",  32'(bus8.ovf),  0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_done", 32'(bus8.done), 0);
      tick();
    end

    // Back-to-back: start held across DONE.
    bus8.a = 8'h12; bus8.b = 8'h34; bus8.cin = 1'b1; bus8.start = 1'b1;
    tick();
    q8.push_back(model(8, 32'h12, 32'h34, 1'b1));
    bus8.a = 8'hC8; bus8.b = 8'h64; bus8.cin = 1'b0;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus8.done) seen = 1;
      else tick();
    end
    chk("b2b_first_done", 32'(seen), 1);
    tick();
    q8.push_back(model(8, 32'hC8, 32'h64, 1'b0));
    bus8.start = 1'b0;
    chk("b2b_no_idle", 32'(bus8.busy), 1);
    n = 1;
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      if (bus8.done) seen = 1;
      else begin tick(); n++; end
    end
    chk("b2b_second_done", 32'(seen), 1);
    chk("b2b_spacing",     32'(n),    9);
    tick();

    // WIDTH=2 exhaustive sweep.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        for (int c = 0; c < 2; c++) begin
          bus2.a = 2'(a); bus2.b = 2'(b); bus2.cin = 1'(c); bus2.start = 1'b1;
          tick();
          q2.push_back(model(2, 32'(a), 32'(b), 1'(c)));
          bus2.start = 1'b0;
          seen = 0;
          for (int i = 0; i < 10 && !seen; i++) begin
            if (bus2.done) seen = 1;
            else tick();
          end
          if (!seen) chk("w2_done_timeout", 0, 1);
          tick();
        end

    tick();
    chk("w8_queue_drained", 32'(q8.size()), 0);
    chk("w2_queue_drained", 32'(q2.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
